// File: rtl/eth_tx_pkg.sv
// Shared speed encodings, periods and state enum for the RGMII TX clock generator.
// ETH_TX_10M_EN enables 10M support and widens the phase counter.
package eth_tx_pkg;

  typedef logic [1:0] speed_t;

  localparam speed_t SPD_10   = 2'b00;
  localparam speed_t SPD_100  = 2'b01;
  localparam speed_t SPD_1000 = 2'b10;

  localparam int PER_100 = 5;
  localparam int PER_10  = 50;

`ifdef ETH_TX_10M_EN
  localparam int PH_W = 6;
`else
  localparam int PH_W = 3;
`endif

  typedef logic [PH_W-1:0] ph_t;

  typedef enum logic {
    ST_RUN,
    ST_PEND
  } state_e;

  function automatic logic spd_valid(speed_t s);
`ifdef ETH_TX_10M_EN
    return s != 2'b11;
`else
    return (s == SPD_100) || (s == SPD_1000);
`endif
  endfunction

  function automatic ph_t ph_last(speed_t s);
    ph_t r;
    r = '0;
    if (s == SPD_100) r = ph_t'(PER_100 - 1);
`ifdef ETH_TX_10M_EN
    if (s == SPD_10) r = ph_t'(PER_10 - 1);
`endif
    return r;
  endfunction

endpackage

// File: rtl/eth_tx_clk_if.sv
// Control and strobe bundle between the TX data path and the clock generator.
// Width of nothing here depends on ETH_TX_10M_EN.
interface eth_tx_clk_if;
  import eth_tx_pkg::*;

  logic   link_up;
  speed_t speed_req;
  logic   frame_active;
  logic   txc_d1;
  logic   txc_d2;
  logic   nib_ce;
  logic   nib_hi;
  logic   byte_ce;
  speed_t speed_cur;
  logic   speed_chg;
  logic   tx_ready;

  modport master (
    output link_up, speed_req, frame_active,
    input  txc_d1, txc_d2, nib_ce, nib_hi,
    input  byte_ce, speed_cur, speed_chg, tx_ready
  );

  modport slave (
    input  link_up, speed_req, frame_active,
    output txc_d1, txc_d2, nib_ce, nib_hi,
    output byte_ce, speed_cur, speed_chg, tx_ready
  );
endinterface

// File: rtl/eth_tx_phase_cnt.sv
// Phase/nibble counter with registered TXC and strobe decode.
// ETH_TX_10M_EN adds the 10M decode branch.
module eth_tx_phase_cnt
  import eth_tx_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  speed_t speed_i,
  input  logic   clr_i,
  output ph_t    ph_o,
  output logic   nh_o,
  output logic   txc_d1_o,
  output logic   txc_d2_o,
  output logic   nib_ce_o,
  output logic   nib_hi_o,
  output logic   byte_ce_o
);

  ph_t  ph_q, ph_d, last;
  logic nh_q, nh_d, wrap;
  logic d1_q, d1_d, d2_q, d2_d;
  logic nce_q, nce_d, nhi_q, nhi_d;
  logic bce_q, bce_d;

  assign last = ph_last(speed_i);

  always_comb begin
    wrap = (ph_q == last);
    ph_d = wrap ? '0 : ph_q + 1'b1;
    nh_d = nh_q ^ wrap;
    if (clr_i) begin
      ph_d = '0;
      nh_d = 1'b0;
    end
  end

  // default decode is the 1000M pattern
  always_comb begin
    d1_d  = 1'b1;
    d2_d  = 1'b0;
    nce_d = 1'b0;
    nhi_d = 1'b0;
    bce_d = 1'b1;
    unique case (1'b1)
`ifdef ETH_TX_10M_EN
      (speed_i == SPD_10): begin
        d1_d  = ph_q < ph_t'(PER_10 / 2);
        d2_d  = d1_d;
        nce_d = ph_q == '0;
        nhi_d = nh_q;
        bce_d = (ph_q == '0) && !nh_q;
      end
`endif
      (speed_i == SPD_100): begin
        d1_d  = ph_q < ph_t'(3);
        d2_d  = ph_q < ph_t'(2);
        nce_d = ph_q == '0;
        nhi_d = nh_q;
        bce_d = (ph_q == '0) && !nh_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ph_q  <= '0;
      nh_q  <= 1'b0;
      d1_q  <= 1'b0;
      d2_q  <= 1'b0;
      nce_q <= 1'b0;
      nhi_q <= 1'b0;
      bce_q <= 1'b0;
    end else begin
      ph_q  <= ph_d;
      nh_q  <= nh_d;
      d1_q  <= d1_d;
      d2_q  <= d2_d;
      nce_q <= nce_d;
      nhi_q <= nhi_d;
      bce_q <= bce_d;
    end
  end

  assign ph_o      = ph_q;
  assign nh_o      = nh_q;
  assign txc_d1_o  = d1_q;
  assign txc_d2_o  = d2_q;
  assign nib_ce_o  = nce_q;
  assign nib_hi_o  = nhi_q;
  assign byte_ce_o = bce_q;

endmodule

// File: rtl/eth_tx_clk_gen.sv
// RGMII TX clock/strobe generator with byte-aligned speed-change FSM.
// ETH_TX_10M_EN enables the 10 Mbit/s mode.
module eth_tx_clk_gen
  import eth_tx_pkg::*;
(
  input  logic         clk125,
  input  logic         rst,
  eth_tx_clk_if.slave  bus
);

  state_e state_q, state_d;
  speed_t cur_q, cur_d;
  speed_t tgt_q, tgt_d;
  logic   chg_q, chg_d;
  logic   rdy_q, rdy_d;
  logic   req_ok, eob;
  ph_t    ph;
  logic   nh;
  logic   d1, d2, nce, nhi, bce;

  eth_tx_phase_cnt u_phase (
    .clk_i     (clk125),
    .rst_i     (rst),
    .speed_i   (cur_q),
    .clr_i     (chg_d),
    .ph_o      (ph),
    .nh_o      (nh),
    .txc_d1_o  (d1),
    .txc_d2_o  (d2),
    .nib_ce_o  (nce),
    .nib_hi_o  (nhi),
    .byte_ce_o (bce)
  );

  assign req_ok = spd_valid(bus.speed_req)
               && (bus.speed_req != cur_q);

  assign eob = (cur_q == SPD_1000)
            || ((ph == ph_last(cur_q)) && nh);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    chg_d   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (req_ok) begin
          state_d = ST_PEND;
          tgt_d   = bus.speed_req;
        end
      end
      ST_PEND: begin
        if (req_ok) tgt_d = bus.speed_req;
        if (bus.speed_req == cur_q) begin
          state_d = ST_RUN;
        end else if (!bus.link_up
                  || (!bus.frame_active && eob)) begin
          // link down skips byte alignment: PHY clock may glitch
          state_d = ST_RUN;
          cur_d   = tgt_d;
          chg_d   = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
    rdy_d = bus.link_up && (state_d == ST_RUN);
  end

  always_ff @(posedge clk125) begin
    if (rst) begin
      state_q <= ST_RUN;
      cur_q   <= SPD_1000;
      tgt_q   <= SPD_1000;
      chg_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      chg_q   <= chg_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.txc_d1    = d1;
  assign bus.txc_d2    = d2;
  assign bus.nib_ce    = nce;
  assign bus.nib_hi    = nhi;
  assign bus.byte_ce   = bce;
  assign bus.speed_cur = cur_q;
  assign bus.speed_chg = chg_q;
  assign bus.tx_ready  = rdy_q;

endmodule

// File: tb/tb_eth_tx_clk_gen.sv
// Self-checking bench for eth_tx_clk_gen: vector table, corner sequences, random run.
// The 10M sequences are built when ETH_TX_10M_EN is defined.
module tb_eth_tx_clk_gen;
  import eth_tx_pkg::*;

  logic clk125 = 1'b0;
  logic rst = 1'b1;

  eth_tx_clk_if bus();

  eth_tx_clk_gen dut (
    .clk125 (clk125),
    .rst    (rst),
    .bus    (bus)
  );

  always #4 clk125 = ~clk125;

  int nchk = 0;
  int nerr = 0;

  int         m_pos;
  logic [1:0] m_spd, m_tgt;
  bit         m_pend;

  logic       e_d1, e_d2, e_nce, e_nhi, e_bce;
  logic       e_chg, e_rdy;
  logic [1:0] e_cur;

  typedef struct {
    logic       lk;
    logic [1:0] rq;
    logic       fa;
    logic [1:0] cur;
    logic       chg;
    logic       rdy;
    logic       bce;
  } vec_t;

  vec_t tbl[11];

  function automatic int per(logic [1:0] s);
    if (s == 2'b01) return 5;
    if (s == 2'b00) return 50;
    return 1;
  endfunction

  function automatic bit valid_req(logic [1:0] s);
`ifdef ETH_TX_10M_EN
    return s != 2'b11;
`else
    return (s == 2'b01) || (s == 2'b10);
`endif
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: position within one byte period; TXC high for the first
  // half of each N-cycle period at half-cycle resolution.
  task automatic model_step();
    int n, ph;
    bit nh, eob, chg;
    logic [1:0] rq;
    if (rst) begin
      {e_d1, e_d2, e_nce, e_nhi, e_bce} = '0;
      e_chg = 0; e_rdy = 0; e_cur = 2'b10;
      m_pos = 0; m_spd = 2'b10; m_tgt = 2'b10; m_pend = 0;
      return;
    end
    rq = bus.speed_req;
    n  = per(m_spd);
    ph = m_pos % n;
    nh = (m_pos >= n);
    e_d1 = (2 * ph < n);
    e_d2 = (2 * ph + 1 < n);
    if (n == 1) begin
      e_bce = 1; e_nce = 0; e_nhi = 0;
    end else begin
      e_nce = (ph == 0);
      e_nhi = nh;
      e_bce = (m_pos == 0);
    end
    chg = 0;
    if (!m_pend) begin
      if (valid_req(rq) && rq != m_spd) begin
        m_pend = 1;
        m_tgt  = rq;
      end
    end else begin
      if (valid_req(rq) && rq != m_spd) m_tgt = rq;
      eob = (n == 1) || (m_pos == 2 * n - 1);
      if (rq == m_spd) m_pend = 0;
      else if (!bus.link_up || (!bus.frame_active && eob)) begin
        m_spd = m_tgt; m_pend = 0; chg = 1; m_pos = 0;
      end
    end
    if (!chg) m_pos = (m_pos + 1) % (2 * n);
    e_cur = m_spd;
    e_chg = chg;
    e_rdy = bus.link_up && !m_pend;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk125);
    #1;
    chk("txc_d1", 8'(bus.txc_d1), 8'(e_d1));
    chk("txc_d2", 8'(bus.txc_d2), 8'(e_d2));
    chk("nib_ce", 8'(bus.nib_ce), 8'(e_nce));
    chk("nib_hi", 8'(bus.nib_hi), 8'(e_nhi));
    chk("byte_ce", 8'(bus.byte_ce), 8'(e_bce));
    chk("speed_cur", 8'(bus.speed_cur), 8'(e_cur));
    chk("speed_chg", 8'(bus.speed_chg), 8'(e_chg));
    chk("tx_ready", 8'(bus.tx_ready), 8'(e_rdy));
  endtask

  task automatic wait_chg(string nm, int lim);
    bit got;
    got = 0;
    for (int w = 0; w < lim && !got; w++) begin
      tick();
      if (bus.speed_chg) got = 1;
    end
    chk(nm, 8'(got), 8'd1);
  endtask

  logic [1:0] pat[5];

  initial begin
    pat = '{2'b11, 2'b11, 2'b10, 2'b00, 2'b00};
    tbl[0]  = '{1'b1, 2'b10, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 2'b01, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 2'b01, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 2'b11, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 2'b10, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 2'b01, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 2'b10, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 2'b11, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 2'b10, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 2'b10, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1};

    bus.link_up      = 1'b1;
    bus.speed_req    = 2'b10;
    bus.frame_active = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_cur", 8'(bus.speed_cur), 8'd2);
    chk("rst_rdy", 8'(bus.tx_ready), 8'd0);
    chk("rst_bce", 8'(bus.byte_ce), 8'd0);
    chk("rst_txc", 8'({bus.txc_d1, bus.txc_d2}), 8'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      bus.link_up      = tbl[i].lk;
      bus.speed_req    = tbl[i].rq;
      bus.frame_active = tbl[i].fa;
      tick();
      chk($sformatf("tbl%0d_cur", i), 8'(bus.speed_cur), 8'(tbl[i].cur));
      chk($sformatf("tbl%0d_chg", i), 8'(bus.speed_chg), 8'(tbl[i].chg));
      chk($sformatf("tbl%0d_rdy", i), 8'(bus.tx_ready), 8'(tbl[i].rdy));
      chk($sformatf("tbl%0d_bce", i), 8'(bus.byte_ce), 8'(tbl[i].bce));
    end

    // 1000M -> 100M, then check the 100M waveform
    bus.speed_req = 2'b01;
    wait_chg("seqA_chg", 10);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("seqA_txc", 8'({bus.txc_d1, bus.txc_d2}), 8'(pat[k % 5]));
      chk("seqA_bce", 8'(bus.byte_ce), 8'(k % 10 == 0));
      chk("seqA_nce", 8'(bus.nib_ce), 8'(k % 5 == 0));
    end

`ifdef ETH_TX_10M_EN
    bus.frame_active = 1'b1;
    bus.speed_req    = 2'b00;
    for (int k = 0; k < 200; k++) begin
      tick();
      chk("seqB_hold", 8'(bus.speed_cur), 8'd1);
    end
    bus.frame_active = 1'b0;
    wait_chg("seqB_chg", 20);
    chk("seqB_end_txc", 8'({bus.txc_d1, bus.txc_d2}), 8'd0);
    chk("seqB_end_nce", 8'(bus.nib_ce), 8'd0);
    for (int k = 0; k < 200; k++) begin
      tick();
      chk("seqB_txc", 8'({bus.txc_d1, bus.txc_d2}),
          (k % 50 < 25) ? 8'd3 : 8'd0);
      chk("seqB_bce", 8'(bus.byte_ce), 8'(k % 100 == 0));
    end
`else
    bus.speed_req = 2'b00;
    for (int k = 0; k < 30; k++) begin
      if (k == 15) bus.speed_req = 2'b11;
      tick();
      chk("seqC_cur", 8'(bus.speed_cur), 8'd1);
      chk("seqC_chg", 8'(bus.speed_chg), 8'd0);
      chk("seqC_rdy", 8'(bus.tx_ready), 8'd1);
    end
`endif

    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 39) == 0)
        bus.speed_req = 2'($urandom_range(0, 3));
      if (bus.link_up) bus.link_up = ($urandom_range(0, 199) != 0);
      else bus.link_up = ($urandom_range(0, 9) == 0);
      if (bus.frame_active)
        bus.frame_active = ($urandom_range(0, 39) != 0);
      else if (!m_pend)
        bus.frame_active = ($urandom_range(0, 14) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
